// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder_ctrl : W-bit add on one shared 4-bit ripple adder,
// one nibble per clock.  Optional macro NSA_SUB_EN adds op_sub (A - B).
// Revision: 1.0
// ============================================================================
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 carry_in,
`ifdef NSA_SUB_EN
   input  logic                 op_sub,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 carry_out
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    a_lat;
   logic [W-1:0]    b_lat;
   logic [IW-1:0]   idx;
   logic            carry_reg;
   logic            init_carry;
   logic [3:0]      nib_a;
   logic [3:0]      nib_b;
   logic [3:0]      nib_sum;
   logic            nib_cout;
`ifdef NSA_SUB_EN
   logic            sub_lat;
`endif

   // Subtraction is A + ~B + 1, so the initial carry is forced high.
`ifdef NSA_SUB_EN
   assign init_carry = op_sub ? 1'b1 : carry_in;
`else
   assign init_carry = carry_in;
`endif

   always_comb begin
      nib_a = a_lat[{idx, 2'b00} +: 4];
`ifdef NSA_SUB_EN
      nib_b = sub_lat ? ~b_lat[{idx, 2'b00} +: 4] : b_lat[{idx, 2'b00} +: 4];
`else
      nib_b = b_lat[{idx, 2'b00} +: 4];
`endif
   end

   // Shared 4-bit ripple adder: four full-adder slices chained on the carry.
   always_comb begin : ripple
      logic c;
      c       = carry_reg;
      nib_sum = '0;
      for (int i = 0; i < 4; i++) begin
         nib_sum[i] = nib_a[i] ^ nib_b[i] ^ c;
         c          = (nib_a[i] & nib_b[i]) | (c & (nib_a[i] ^ nib_b[i]));
      end
      nib_cout = c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_lat     <= '0;
         b_lat     <= '0;
         idx       <= '0;
         carry_reg <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef NSA_SUB_EN
         sub_lat   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_lat     <= a;
                  b_lat     <= b;
`ifdef NSA_SUB_EN
                  sub_lat   <= op_sub;
`endif
                  idx       <= '0;
                  carry_reg <= init_carry;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               sum[{idx, 2'b00} +: 4] <= nib_sum;
               carry_reg              <= nib_cout;
               // Index parks on the last nibble rather than wrapping to 0.
               if (idx == LAST_IDX) begin
                  carry_out <= nib_cout;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nibble_serial_adder_ctrl : scoreboard bench for nibble_serial_adder_ctrl.
// Revision: 1.0
// ============================================================================
module tb_nibble_serial_adder_ctrl;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          carry_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          carry_out;
`ifdef NSA_SUB_EN
   logic          op_sub;
`endif

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
`ifdef NSA_SUB_EN
      .op_sub    (op_sub),
`endif
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push expected result, pulse start, wait for done, pop and compare.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cin, input logic sub, input string name);
      exp_t       e;
      logic [W:0] full;
      int         bc;
      bit         seen;
      if (sub) full = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
      else     full = {1'b0, av} + {1'b0, bv} + (W+1)'(cin);
      e.s = full[W-1:0];
      e.c = full[W];
      sb.push_back(e);
      a = av; b = bv; carry_in = cin;
`ifdef NSA_SUB_EN
      op_sub = sub;
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      bc = 0; seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin seen = 1'b1; break; end
         if (busy) bc++;
         tick();
      end
      e = sb.pop_front();
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s done_timeout got=0 exp=1", name);
      end else begin
         checks++;
         if (bc !== 4) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=4", name, bc);
         end
         checks++;
         if (sum !== e.s) begin
            failures++;
            $display("FAIL %s sum got=%h exp=%h", name, sum, e.s);
         end
         checks++;
         if (carry_out !== e.c) begin
            failures++;
            $display("FAIL %s carry_out got=%b exp=%b", name, carry_out, e.c);
         end
         tick();
         checks++;
         if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse_width got=%b exp=0", name, done);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; a = 16'hABCD; b = 16'h1234; carry_in = 1'b1;
`ifdef NSA_SUB_EN
      op_sub = 1'b0;
`endif
      repeat (3) tick();
      start = 1'b0;
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset done got=%b exp=0", done); end
      checks++; if (sum !== 16'h0)  begin failures++; $display("FAIL reset sum got=%h exp=0000", sum); end
      checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL reset carry_out got=%b exp=0", carry_out); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_release busy got=%b exp=0", busy); end
   endtask

   task automatic test_basic();
      run_op(16'h0003, 16'h0006, 1'b0, 1'b0, "basic_3_6");
      repeat (3) tick();
      checks++;
      if (sum !== 16'h0009) begin failures++; $display("FAIL idle_hold sum got=%h exp=0009", sum); end
   endtask

   task automatic test_boundaries();
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap_ffff_1");
      run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "zero_cin");
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "max_all");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++)
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, "b2b_random");
   endtask

   // start held through RUN and the DONE cycle must not retrigger.
   task automatic test_start_ignored();
      exp_t e;
      int   pulses;
      bit   late_busy;
      e.s = 16'h1000; e.c = 1'b0;
      sb.push_back(e);
      a = 16'h0F0F; b = 16'h00F1; carry_in = 1'b0;
`ifdef NSA_SUB_EN
      op_sub = 1'b0;
`endif
      start = 1'b1;
      tick();
      a = 16'h1111;
      pulses = 0;
      for (int k = 0; k < 10 && pulses == 0; k++) begin
         if (done) pulses++;
         else tick();
      end
      tick();
      start = 1'b0;
      late_busy = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done) pulses++;
         if (busy) late_busy = 1'b1;
      end
      e = sb.pop_front();
      checks++; if (pulses !== 1) begin failures++; $display("FAIL ignore_start done_pulses got=%0d exp=1", pulses); end
      checks++; if (late_busy !== 1'b0) begin failures++; $display("FAIL ignore_start retrigger got=%b exp=0", late_busy); end
      checks++; if (sum !== e.s) begin failures++; $display("FAIL ignore_start sum got=%h exp=%h", sum, e.s); end
      checks++; if (carry_out !== e.c) begin failures++; $display("FAIL ignore_start carry_out got=%b exp=%b", carry_out, e.c); end
   endtask

   // Prior sum is 0x1000; unprocessed nibbles must keep their old value.
   task automatic test_partial();
      a = 16'h0001; b = 16'h0001; carry_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++; if (sum !== 16'h1002) begin failures++; $display("FAIL partial_n0 sum got=%h exp=1002", sum); end
      tick(); tick();
      checks++; if (sum !== 16'h1002) begin failures++; $display("FAIL partial_n2 sum got=%h exp=1002", sum); end
      tick();
      checks++; if (sum !== 16'h0002) begin failures++; $display("FAIL partial_final sum got=%h exp=0002", sum); end
      checks++; if (done !== 1'b1)    begin failures++; $display("FAIL partial_final done got=%b exp=1", done); end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      a = 16'h1234; b = 16'h1111; carry_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL abort busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)  begin failures++; $display("FAIL abort done got=%b exp=0", done); end
      checks++; if (sum !== 16'h0)  begin failures++; $display("FAIL abort sum got=%h exp=0000", sum); end
      checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL abort carry_out got=%b exp=0", carry_out); end
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done || busy) pulses++;
      end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL abort late_activity got=%0d exp=0", pulses); end
   endtask

`ifdef NSA_SUB_EN
   task automatic test_sub();
      run_op(16'h0005, 16'h0003, 1'b0, 1'b1, "sub_5_3");
      run_op(16'h0003, 16'h0005, 1'b1, 1'b1, "sub_3_5");
      run_op(16'h8000, 16'h8000, 1'b0, 1'b1, "sub_equal");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_back_to_back();
      test_start_ignored();
      test_partial();
      test_reset_mid_run();
`ifdef NSA_SUB_EN
      test_sub();
`endif
      test_basic();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; legal range 2..16; operand width W = 4*NIBBLES.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  W  operand A; sampled on the accepting edge.
REQ-006 Port: b  input  W  operand B; sampled on the accepting edge.
REQ-007 Port: carry_in  input  1  initial carry into nibble 0; sampled on the accepting edge.
REQ-008 Port: op_sub  input  1  subtract select; present only when NSA_SUB_EN is defined.
REQ-009 Port: busy  output  1  high while the nibble sequence is running.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: sum  output  W  registered result.
REQ-012 Port: carry_out  output  1  registered carry out of the most significant nibble.

Function
REQ-013 The block SHALL contain one 4-bit ripple adder, built from four full-adder slices, shared across all nibbles; no W-bit adder.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; transitions: IDLE->RUN on start=1; RUN->DONE after nibble NIBBLES-1; DONE->IDLE unconditionally.
REQ-015 On the accepting edge the block SHALL latch a, b, carry_in (and op_sub), load the nibble index with 0, and load the carry register with carry_in.
REQ-016 In RUN, each edge SHALL write adder sum into sum[4i+3:4i] for index i, store the adder carry in the carry register, and increment i.
REQ-017 Nibble i SHALL use latched A[4i+3:4i], latched B[4i+3:4i], and the carry register as adder inputs.
REQ-018 The final-nibble edge SHALL load carry_out with the adder carry and set done=1; done SHALL be 0 in every other cycle.
REQ-019 Latency: done SHALL be high in the cycle following the NIBBLES-th rising edge after the accepting edge.
REQ-020 busy SHALL be 1 exactly in RUN; start while busy or in DONE SHALL be ignored without side effects.
REQ-021 sum and carry_out SHALL hold their last values in IDLE and DONE; bits of nibbles not yet processed in RUN SHALL keep their prior values.
REQ-022 Arithmetic SHALL be modulo 2^W; {carry_out, sum} SHALL equal A + B + carry_in.
REQ-023 The nibble index SHALL never exceed NIBBLES-1; no wrap into nibble 0 within one operation.

Reset
REQ-024 With rst_n=0 at a rising edge, state SHALL become IDLE; busy, done, carry_out, sum, index, carry register, and latched operands SHALL all become 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; start SHALL be ignored while rst_n=0.

Configuration
REQ-026 Macro NSA_SUB_EN: when defined, op_sub exists; with op_sub=1 latched, B nibbles SHALL be inverted and the initial carry SHALL be forced to 1, ignoring carry_in, giving A - B with carry_out=1 meaning no borrow.
REQ-027 Without NSA_SUB_EN, op_sub SHALL not exist and the block SHALL only add.

Verification (NIBBLES=4)
REQ-028 a=0x0003, b=0x0006, carry_in=0, start pulse -> busy for 4 cycles, then done=1 for one cycle, sum=0x0009, carry_out=0.
REQ-029 a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, carry_out=1; a=0x0000, b=0x0000, carry_in=1 -> sum=0x0001, carry_out=0.
REQ-030 start re-asserted with a=0x1111 during RUN of 0x0F0F+0x00F1 -> ignored; result 0x1000, exactly one done pulse.
REQ-031 rst_n=0 on the second RUN edge -> next cycle busy=0, done=0, sum=0x0000, carry_out=0; no later done pulse.
REQ-032 With NSA_SUB_EN defined: a=0x0005, b=0x0003, op_sub=1 -> sum=0x0002, carry_out=1; a=0x0003, b=0x0005 -> sum=0xFFFE, carry_out=0.
